rsa_modexp_core: RTL and testbench

//  Modular-exponentiation engine behind the RSA byte-addressed register file.

---
 rtl/rsa_modexp_core_if.sv | 21 ++
 rtl/rsa_modexp_core.sv | 177 +++++++++++++++++
 tb/tb_rsa_modexp_core.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_core_if.sv
// Operand/result bundle between the RSA register file and the modexp engine.
interface rsa_modexp_core_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] n_i;
    logic [WIDTH-1:0] e_i;
    logic [WIDTH-1:0] m_i;
    logic             ready;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start, n_i, e_i, m_i,
        input  ready, result_o
    );

    modport slave (
        input  start, n_i, e_i, m_i,
        output ready, result_o
    );
endinterface

// File: rtl/rsa_modexp_core.sv
// R = M^E mod N via right-to-left binary exponentiation on two parallel bit-serial Blakley multipliers.
// Optional RSA_EARLY_EXIT_EN stops EXP once the remaining exponent is zero; default is constant-time.
module rsa_modexp_core #(
    parameter int WIDTH = 256
) (
    input  logic               clk,
    input  logic               reset,
    rsa_modexp_core_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = WIDTH + 2;

`ifdef RSA_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_EXP,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_base;
    logic [PW-1:0]    r_p1;
    logic [PW-1:0]    r_p2;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_ecnt;
    logic             r_ready;
    logic [WIDTH-1:0] r_result;

    logic             w_a1_bit;
    logic             w_a2_bit;
    logic [WIDTH-1:0] w_b1;
    logic [PW-1:0]    w_n_ext;
    logic [PW-1:0]    w_p1_dbl;
    logic [PW-1:0]    w_p1_s1;
    logic [PW-1:0]    w_p1_s2;
    logic [PW-1:0]    w_p2_dbl;
    logic [PW-1:0]    w_p2_s1;
    logic [PW-1:0]    w_p2_s2;
    logic             w_last;
    logic             w_accept;

    assign bus.ready    = r_ready;
    assign bus.result_o = r_result;

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_last   = (r_cnt == '0);
    assign w_n_ext  = {2'b00, r_n};

    // Multiplier 1 reduces M (times 1) in REDUCE, then forms acc*base in EXP.
    assign w_a1_bit = (r_state == ST_REDUCE) ? r_m[r_cnt] : r_acc[r_cnt];
    assign w_b1     = (r_state == ST_REDUCE) ? WIDTH'(1) : r_base;
    assign w_a2_bit = r_base[r_cnt];

    // 2P + B < 3N, so two conditional subtractions restore P < N.
    assign w_p1_dbl = {r_p1[PW-2:0], 1'b0} + (w_a1_bit ? {2'b00, w_b1} : '0);
    assign w_p1_s1  = (w_p1_dbl >= w_n_ext) ? (w_p1_dbl - w_n_ext) : w_p1_dbl;
    assign w_p1_s2  = (w_p1_s1  >= w_n_ext) ? (w_p1_s1  - w_n_ext) : w_p1_s1;

    assign w_p2_dbl = {r_p2[PW-2:0], 1'b0} + (w_a2_bit ? {2'b00, r_base} : '0);
    assign w_p2_s1  = (w_p2_dbl >= w_n_ext) ? (w_p2_dbl - w_n_ext) : w_p2_dbl;
    assign w_p2_s2  = (w_p2_s1  >= w_n_ext) ? (w_p2_s1  - w_n_ext) : w_p2_s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.n_i < WIDTH'(2)) ? ST_DONE : ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (w_last) begin
                    w_state_nxt = (EARLY && (r_e == '0)) ? ST_DONE : ST_EXP;
                end
            end
            ST_EXP: begin
                if (w_last) begin
                    if (EARLY) begin
                        if (r_e[WIDTH-1:1] == '0) w_state_nxt = ST_DONE;
                    end else if (r_ecnt == CW'(WIDTH - 1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_n      <= '0;
            r_e      <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_base   <= '0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_cnt    <= '0;
            r_ecnt   <= '0;
            r_ready  <= 1'b1;
            r_result <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_n     <= bus.n_i;
                        r_e     <= bus.e_i;
                        r_m     <= bus.m_i;
                        r_acc   <= '0;
                        r_base  <= '0;
                        r_p1    <= '0;
                        r_p2    <= '0;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_ecnt  <= '0;
                        r_ready <= 1'b0;
                    end
                end
                ST_REDUCE: begin
                    r_p1  <= w_p1_s2;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_base <= w_p1_s2[WIDTH-1:0];
                        r_acc  <= WIDTH'(1);
                        r_p1   <= '0;
                        r_cnt  <= CW'(WIDTH - 1);
                    end
                end
                ST_EXP: begin
                    r_p1  <= w_p1_s2;
                    r_p2  <= w_p2_s2;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        if (r_e[0]) r_acc <= w_p1_s2[WIDTH-1:0];
                        r_base <= w_p2_s2[WIDTH-1:0];
                        r_e    <= r_e >> 1;
                        r_ecnt <= r_ecnt + CW'(1);
                        r_p1   <= '0;
                        r_p2   <= '0;
                        r_cnt  <= CW'(WIDTH - 1);
                    end
                end
                ST_DONE: begin
                    r_result <= r_acc;
                    r_ready  <= 1'b1;
                end
                default: begin
                    r_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Self-checking bench for rsa_modexp_core at WIDTH=8 against a naive repeated-multiply model.
module tb_rsa_modexp_core;
    localparam int W     = 8;
    localparam int LAT   = 1 + W + W * W;
    localparam int BOUND = 5000;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    rsa_modexp_core_if #(.WIDTH(W)) bus ();

    rsa_modexp_core #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_pow(input int n, input int e, input int m);
        int r;
        if (n < 2) return 0;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * m) % n;
        return r;
    endfunction

    task automatic drive_start(input int n, input int e, input int m);
        @(negedge clk);
        bus.n_i   = W'(n);
        bus.e_i   = W'(e);
        bus.m_i   = W'(m);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input int n, input int e, input int m);
        int lat;
        int exp_lat;
        drive_start(n, e, m);
        lat = 0;
        while (!bus.ready && lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
        end
        exp_lat = (n < 2) ? 1 : LAT;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, {24'd0, bus.result_o}, ref_pow(n, e, m));
    endtask

    initial begin
        int cyc;
        int rn, re, rm;
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.n_i   = '0;
        bus.e_i   = '0;
        bus.m_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.ready}, 1);
        chk("rst_result", {24'd0, bus.result_o}, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("d1", 33, 7, 4);
        chk("d1_val16", {24'd0, bus.result_o}, 16);
        run_op("d2a", 33, 3, 200);
        run_op("d2b", 33, 0, 5);
        run_op("d3a", 1, 5, 7);
        run_op("d3b", 0, 5, 7);
        run_op("m0", 77, 9, 0);
        run_op("m0e0", 77, 0, 0);
        run_op("maxall", 255, 255, 255);
        run_op("n2", 2, 255, 3);

        // Port changes and start pulses while busy must be ignored.
        drive_start(33, 7, 4);
        cyc = 0;
        while (!bus.ready && cyc < BOUND) begin
            @(negedge clk);
            if (cyc == 10 || cyc == 40) begin
                bus.start = 1'b1;
                bus.n_i   = W'($urandom);
                bus.e_i   = W'($urandom);
                bus.m_i   = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        chk("busy_lat", cyc, LAT);
        chk("busy_res", {24'd0, bus.result_o}, 16);

        // Mid-operation reset aborts; start coincident with reset is dropped.
        drive_start(33, 7, 4);
        repeat (29) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", {31'd0, bus.ready}, 1);
        chk("abort_result", {24'd0, bus.result_o}, 0);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_start_drop", {31'd0, bus.ready}, 1);
        run_op("restart", 33, 3, 200);

        for (int i = 0; i < 40; i++) begin
            rn = $urandom_range(255, 2);
            re = $urandom_range(255, 0);
            rm = $urandom_range(255, 0);
            if (i % 10 == 3) re = 0;
            run_op("rand", rn, re, rm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
